// File: rtl/sram_like_arbiter.sv
// Register FIFO with no bypass: the caller never pushes when full or pops when empty.
// Zero-latency read of the head entry.
module sync_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push_vld,
   input  logic [W-1:0]     push_dat,
   input  logic             pop_vld,
   output logic [W-1:0]     pop_dat,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_vld) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_vld)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_vld && !pop_vld)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop_vld && !push_vld) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_vld) mem_q[wr_ptr_q] <= push_dat;
   end

   assign pop_dat = mem_q[rd_ptr_q];
   assign count   = cnt_q;

endmodule

// N-to-1 sram-like arbiter with in-order response routing; grant and addr_ok/data_ok are zero latency.
// Backpressure: mem_addr_ok stalls the granted master (grant locked), and a full ID FIFO drops mem_req.
module sram_like_arbiter #(
   parameter int NUM_CH          = 2,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int RR_MODE         = 0,
   localparam int STRB_W = DATA_W / 8,
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_wr,
   input  logic [2*NUM_CH-1:0]      ch_size,
   input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
   input  logic [STRB_W*NUM_CH-1:0] ch_wstrb,
   input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
   output logic [NUM_CH-1:0]        ch_addr_ok,
   output logic [NUM_CH-1:0]        ch_data_ok,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic                     mem_req,
   output logic                     mem_wr,
   output logic [1:0]               mem_size,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [STRB_W-1:0]        mem_wstrb,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic                     mem_addr_ok,
   input  logic                     mem_data_ok,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic [CNT_W-1:0]         outstanding,
   output logic                     err_orphan
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              lock_vld_q, lock_vld_d;
   logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic              err_orphan_q, err_orphan_d;
   logic [CH_W-1:0]   winner, grant, head_ch;
   logic              rr_found;
   logic              full, hs, pop;
   logic [CNT_W-1:0]  count;

   // Round robin scans channels in order rr_ptr, rr_ptr+1, ... wrapping at NUM_CH.
   always_comb begin
      winner   = '0;
      rr_found = 1'b0;
      if (RR_MODE == 0) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i]) winner = CH_W'(i);
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (!rr_found && ch_req[i] &&
                   ((int'(rr_ptr_q) + k == i) || (int'(rr_ptr_q) + k == i + NUM_CH))) begin
                  winner   = CH_W'(i);
                  rr_found = 1'b1;
               end
            end
         end
      end
   end

   assign grant   = lock_vld_q ? lock_ch_q : winner;
   assign full    = (count == CNT_W'(MAX_OUTSTANDING));
   assign mem_req = resetn & (lock_vld_q | (|ch_req)) & ~full;
   assign hs      = mem_req & mem_addr_ok;
   assign pop     = mem_data_ok & (count != '0);

   always_comb begin
      mem_wr     = 1'b0;
      mem_size   = '0;
      mem_addr   = '0;
      mem_wstrb  = '0;
      mem_wdata  = '0;
      ch_addr_ok = '0;
      ch_data_ok = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (resetn && grant == CH_W'(i)) begin
            mem_wr    = ch_wr[i];
            mem_size  = ch_size[2*i +: 2];
            mem_addr  = ch_addr[ADDR_W*i +: ADDR_W];
            mem_wstrb = ch_wstrb[STRB_W*i +: STRB_W];
            mem_wdata = ch_wdata[DATA_W*i +: DATA_W];
         end
         ch_addr_ok[i] = hs  && (grant == CH_W'(i));
         ch_data_ok[i] = pop && (head_ch == CH_W'(i));
      end
   end

   assign ch_rdata = resetn ? mem_rdata : '0;

   // A stalled request pins the grant so the downstream payload cannot change under it.
   always_comb begin
      lock_vld_d   = lock_vld_q;
      lock_ch_d    = lock_ch_q;
      rr_ptr_d     = rr_ptr_q;
      err_orphan_d = err_orphan_q | (mem_data_ok & (count == '0));
      if (mem_req && !mem_addr_ok) begin
         lock_vld_d = 1'b1;
         lock_ch_d  = grant;
      end else if (hs) begin
         lock_vld_d = 1'b0;
      end
      if (RR_MODE != 0 && hs) begin
         rr_ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_vld_q   <= 1'b0;
         lock_ch_q    <= '0;
         rr_ptr_q     <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         lock_vld_q   <= lock_vld_d;
         lock_ch_q    <= lock_ch_d;
         rr_ptr_q     <= rr_ptr_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   sync_fifo #(
      .W     (CH_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push_vld (hs),
      .push_dat (grant),
      .pop_vld  (pop),
      .pop_dat  (head_ch),
      .count    (count)
   );

   assign outstanding = count;
   assign err_orphan  = err_orphan_q;

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Parametrised N-channel arbiter between sram-like masters and a single sram-like slave port.
- Masters are the IF fetch port, the EXE/MEM load-store port, and future ports such as a TLB walker or cache refill.
- The slave port feeds the AXI bridge.
- Supports multiple outstanding transactions with in-order responses, and routes each data_ok/rdata back to the channel that issued the request.

Parameters:
- NUM_CH, 2, number of upstream channels (1..8); channel 0 is the fetch port.
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8); STRB_W = DATA_W/8.
- MAX_OUTSTANDING, 4, depth of the issued-channel ID FIFO (power of 2, ≥2).
- RR_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins); 1 = round robin.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ch_req  in  NUM_CH  per-channel request
- ch_wr  in  NUM_CH  per-channel write flag
- ch_size  in  2*NUM_CH  per-channel size (0=byte, 1=half, 2=word)
- ch_addr  in  ADDR_W*NUM_CH  per-channel address, channel i at slice [i*ADDR_W +: ADDR_W]
- ch_wstrb  in  STRB_W*NUM_CH  per-channel byte strobes
- ch_wdata  in  DATA_W*NUM_CH  per-channel write data
- ch_addr_ok  out  NUM_CH  request accepted, one-hot or zero
- ch_data_ok  out  NUM_CH  response valid, one-hot or zero
- ch_rdata  out  DATA_W  read data, broadcast to all channels, qualified by ch_data_ok
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write flag
- mem_size  out  2  downstream size
- mem_addr  out  ADDR_W  downstream address
- mem_wstrb  out  STRB_W  downstream byte strobes
- mem_wdata  out  DATA_W  downstream write data
- mem_addr_ok  in  1  downstream accepted the request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  DATA_W  downstream read data
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  number of issued-but-unanswered requests
- err_orphan  out  1  sticky flag: data_ok arrived with nothing outstanding

Behaviour:
- Protocol: a request handshake occurs on req & addr_ok in the same cycle. Masters hold req/wr/size/addr/wstrb/wdata stable until addr_ok. Responses are in order; data_ok is a single-cycle pulse per transaction, reads and writes alike.
- Reset (resetn low, asynchronous):
  - FIFO pointers, count, lock state and RR pointer all clear to 0; err_orphan = 0.
  - All outputs are 0 while reset is asserted: mem_req, ch_addr_ok, ch_data_ok, ch_rdata = 0.
  - Reset mid-transaction discards every outstanding ID; no data_ok is generated afterward for requests issued before reset.
- full = (outstanding == MAX_OUTSTANDING). A pop in the same cycle does not lift full; there is no bypass.
- Arbitration:
  - Each cycle, if not full and no lock is held, grant goes to the winning requester among ch_req.
  - RR_MODE=0: lowest index wins.
  - RR_MODE=1: the first requester at or after rr_ptr (modulo NUM_CH) wins.
  - mem_req = (lock held or any ch_req) & ~full.
  - mem_* payload is muxed combinationally from the granted channel.
- Grant lock: if mem_req=1 and mem_addr_ok=0, lock_valid <= 1 and lock_ch <= grant. While locked, grant = lock_ch regardless of other requesters. The lock clears on the cycle after a handshake. This keeps the downstream payload stable.
- ch_addr_ok[g] = mem_addr_ok & mem_req for granted channel g; all other bits are 0. Zero latency: same cycle as the downstream handshake.
- On handshake:
  - Push g into the ID FIFO.
  - If RR_MODE=1, rr_ptr <= (g+1) mod NUM_CH.
- On mem_data_ok with outstanding>0:
  - ch_data_ok[head] = 1 combinationally in the same cycle; ch_rdata = mem_rdata.
  - Pop the FIFO.
- On mem_data_ok with outstanding==0: no ch_data_ok, err_orphan <= 1 (sticky until reset).
- Simultaneous push and pop: outstanding is unchanged; the pointers advance independently and wrap modulo MAX_OUTSTANDING.
- A new request on a channel may be issued in the same cycle its previous response returns.
- NUM_CH=1 degenerates to a pass-through plus the outstanding counter; arbitration logic elides.

Test Plan:
- Fixed priority, single cycle: RR_MODE=0, ch_req=2'b11, mem_addr_ok=1 every cycle → ch_addr_ok=01 for cycle 1; ch1 is granted only after ch0 drops req. outstanding increments 0→1→2.
- Grant lock: ch1 requests alone with mem_addr_ok=0 for 3 cycles, ch0 raises req in cycle 2 → mem_addr stays ch1's address all 3 cycles. When addr_ok rises, ch_addr_ok=10; ch0 is granted the next cycle.
- Round robin: RR_MODE=1, NUM_CH=3, all three req held high, addr_ok=1 → grant sequence 0,1,2,0,1,2.
- Full and in-order return: MAX_OUTSTANDING=4, issue ch0,ch1,ch1,ch0 with no data_ok:
  - mem_req=0 with outstanding=4 while ch_req≠0.
  - Then 4 mem_data_ok pulses with rdata 0x11,0x22,0x33,0x44 → ch_data_ok=01,10,10,01 with matching ch_rdata.
  - Same-cycle push/pop at outstanding=3 keeps count 3.
- Orphan response: mem_data_ok at outstanding=0 → ch_data_ok=0, err_orphan=1 and it stays 1.
- Reset mid-flight: 2 outstanding, resetn pulsed low asynchronously mid-cycle → outputs 0 immediately, outstanding=0. A subsequent mem_data_ok sets err_orphan.
